// File: rtl/tpu_matmul_engine.sv
// Output-stationary N x N systolic matrix multiplier (C = A x B) with on-block
// operand buffers, a CLEAR/RUN/DRAIN sequencer and a row-major result stream.
module tpu_matmul_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18,
  parameter int OUT_WIDTH  = 8,
  parameter int SATURATE   = 1,
  localparam int IDX_W     = (N > 2) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [IDX_W-1:0]      wr_row,
  input  logic [IDX_W-1:0]      wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col,
  output logic                  out_last
);

  localparam int KW       = $clog2(3 * N);
  localparam int RUN_LAST = 3 * N - 3;
  localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(longint'(1) <<< (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t                       state, state_nx;
  logic [KW-1:0]                kcnt;
  logic signed [DATA_WIDTH-1:0] a_buf  [N][N];
  logic signed [DATA_WIDTH-1:0] b_buf  [N][N];
  logic signed [DATA_WIDTH-1:0] a_feed [N];
  logic signed [DATA_WIDTH-1:0] b_feed [N];
  logic signed [DATA_WIDTH-1:0] a_in   [N][N];
  logic signed [DATA_WIDTH-1:0] b_in   [N][N];
  logic signed [DATA_WIDTH-1:0] a_p1   [N][N-1];
  logic signed [DATA_WIDTH-1:0] b_p1   [N-1][N];
  logic signed [ACC_WIDTH-1:0]  acc    [N][N];
  logic                         wr_fire, accept, aborting;

  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = a * b;
    return ACC_WIDTH'(prod);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
    if (SATURATE != 0) begin
      if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
      if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    end
    return v[OUT_WIDTH-1:0];
  endfunction

  assign busy     = (state != IDLE);
  assign wr_ready = (state == IDLE);
  assign wr_fire  = wr_valid && wr_ready && ({1'b0, wr_row} < IDX_LIM) && ({1'b0, wr_col} < IDX_LIM);
  assign accept   = out_valid && out_ready;
  assign aborting = abort && (state != IDLE);
  assign out_last = out_valid && (out_row == IDX_MAX) && (out_col == IDX_MAX);
  assign out_data = narrow(acc[out_row][out_col]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (kcnt == KW'(RUN_LAST)) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (aborting) state_nx = IDLE;
  end

  // Skewed edge feed: at RUN cycle k, row i gets A[i][k-i] and column j gets B[k-j][j]
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
    end
    if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        for (int m = 0; m < N; m++) begin
          if (kcnt == KW'(i + m)) begin
            a_feed[i] = a_buf[i][m];
            b_feed[i] = b_buf[m][i];
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_feed[i];
      b_in[0][i] = b_feed[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_p1[i][j-1];
        b_in[j][i] = b_p1[j-1][i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      kcnt      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
          acc[i][j]   <= '0;
        end
        for (int j = 0; j < N - 1; j++) a_p1[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++) b_p1[i][j] <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (wr_fire) begin
        if (wr_sel) b_buf[wr_row][wr_col] <= wr_data;
        else        a_buf[wr_row][wr_col] <= wr_data;
      end
      case (state)
        // ---- CLEAR: zero accumulators and flush operand pipes of any aborted run
        CLEAR: begin
          kcnt    <= '0;
          out_row <= '0;
          out_col <= '0;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) acc[i][j] <= '0;
            for (int j = 0; j < N - 1; j++) a_p1[i][j] <= '0;
          end
          for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N; j++) b_p1[i][j] <= '0;
        end
        // ---- RUN: every PE accumulates and forwards a right, b down
        RUN: begin
          kcnt <= kcnt + KW'(1);
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) acc[i][j] <= acc[i][j] + mac_term(a_in[i][j], b_in[i][j]);
            for (int j = 0; j < N - 1; j++) a_p1[i][j] <= a_in[i][j];
          end
          for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N; j++) b_p1[i][j] <= b_in[i][j];
        end
        // ---- DRAIN: row-major beats; first DRAIN cycle only raises out_valid
        DRAIN: begin
          if (accept) begin
            if (out_last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (out_col == IDX_MAX) begin
              out_col <= '0;
              out_row <= out_row + IDX_W'(1);
            end else begin
              out_col <= out_col + IDX_W'(1);
            end
          end else if (!out_valid && !done) begin
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      if (aborting) begin
        out_valid <= 1'b0;
        done      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpu_matmul_engine.sv
// Self-checking bench for tpu_matmul_engine: directed and random matrices
// compared against a plain-arithmetic matrix-product model.
module tb_tpu_matmul_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int OW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_sel = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [IW-1:0] wr_row = '0, wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, busy, done, out_valid, out_last;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_row, out_col;
  logic          wr_ready_t, busy_t, done_t, out_valid_t, out_last_t;
  logic [OW-1:0] out_data_t;
  logic [IW-1:0] out_row_t, out_col_t;

  int errors = 0;
  int checks = 0;
  int ma [N][N];
  int mb [N][N];
  logic [OW-1:0] exp_sat [N][N];
  logic [OW-1:0] exp_trn [N][N];

  tpu_matmul_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  tpu_matmul_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_t), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start), .abort(abort),
    .busy(busy_t), .done(done_t), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_row(out_row_t), .out_col(out_col_t), .out_last(out_last_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // C = A x B with plain integers, wrapped to the accumulator width, then narrowed
  task automatic build_model();
    longint s;
    logic signed [AW-1:0] w;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        w = AW'(s);
        exp_trn[i][j] = w[OW-1:0];
        if (w > 127)       exp_sat[i][j] = 8'h7F;
        else if (w < -128) exp_sat[i][j] = 8'h80;
        else               exp_sat[i][j] = w[OW-1:0];
      end
    end
  endtask

  task automatic write_elem(input logic sel, input int r, input int c, input int v);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_row   = IW'(r);
    wr_col   = IW'(c);
    wr_data  = DW'(v);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_elem(1'b0, i, j, ma[i][j]);
        write_elem(1'b1, i, j, mb[i][j]);
      end
  endtask

  task automatic fill_rand();
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = DW'($urandom);
        ma[i][j] = int'($signed(r));
        r = DW'($urandom);
        mb[i][j] = int'($signed(r));
      end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_done"},      64'(done), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_last"},  64'(out_last), 64'(0));
    chk({tag, "_out_data"},  64'(out_data), 64'(0));
    chk({tag, "_out_row"},   64'(out_row), 64'(0));
    chk({tag, "_out_col"},   64'(out_col), 64'(0));
    chk({tag, "_wr_ready"},  64'(wr_ready), 64'(1));
  endtask

  // Start a multiply and consume the whole stream; optional stall on one beat
  // and optional write attempts while busy.
  task automatic run_check(input string tag, input int stall_beat, input bit wr_probe);
    int lat, beats, guard, r, c;
    logic [1+1+IW+IW+OW-1:0] held;
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    lat = 0;
    if (wr_probe) begin
      tick();
      lat = 1;
      wr_valid = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'h55;
      chk({tag, "_wr_ready_busy"}, 64'(wr_ready), 64'(0));
    end
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    wr_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(3 * N));
    beats = 0;
    guard = 0;
    while (beats < N * N && guard < 200) begin
      guard++;
      if (out_valid) begin
        r = beats / N;
        c = beats % N;
        if (beats == stall_beat) begin
          held = {out_valid, out_last, out_row, out_col, out_data};
          out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("%s_hold%0d", tag, s), 64'({out_valid, out_last, out_row, out_col, out_data}), 64'(held));
          end
          out_ready = 1'b1;
        end
        chk($sformatf("%s_b%0d_sat", tag, beats), 64'(out_data), 64'(exp_sat[r][c]));
        chk($sformatf("%s_b%0d_trn", tag, beats), 64'(out_data_t), 64'(exp_trn[r][c]));
        chk($sformatf("%s_b%0d_pos", tag, beats), 64'({out_row, out_col}), 64'({IW'(r), IW'(c)}));
        chk($sformatf("%s_b%0d_last", tag, beats), 64'(out_last), 64'(beats == N * N - 1));
        chk($sformatf("%s_b%0d_done", tag, beats), 64'(done), 64'(0));
        tick();
        beats++;
      end else begin
        tick();
      end
    end
    chk({tag, "_beats"}, 64'(beats), 64'(N * N));
    chk({tag, "_end_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(1));
    tick();
    chk({tag, "_done_off"}, 64'(done), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    bit saw_v, saw_d;
    int guard;
    #1 rst_n = 1'b1;
    repeat (2) tick();
    check_reset("por");
    rst_n = 1'b0;
    tick();

    // identity x ramp
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 4 * i + j;
      end
    load_all();
    run_check("ident", -1, 1'b0);

    // abort in the third RUN cycle, then rerun without reloading
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_busy_before", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    saw_v = 1'b0;
    saw_d = 1'b0;
    repeat (3 * N + 5) begin
      tick();
      saw_v |= out_valid;
      saw_d |= done;
    end
    chk("abort_no_valid", 64'(saw_v), 64'(0));
    chk("abort_no_done", 64'(saw_d), 64'(0));
    run_check("rerun", -1, 1'b0);

    // all -1 times all 2
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -1;
        mb[i][j] = 2;
      end
    load_all();
    run_check("neg", -1, 1'b0);

    // saturation vs truncation
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 127;
        mb[i][j] = 127;
      end
    load_all();
    run_check("sat", -1, 1'b0);

    // random operands with backpressure on beat (1,1)
    fill_rand();
    load_all();
    run_check("stall", 5, 1'b0);

    // random operands with write attempts while busy
    fill_rand();
    load_all();
    run_check("wrbusy", -1, 1'b1);
    fill_rand();
    load_all();
    run_check("rand", -1, 1'b0);

    // reset in the middle of the result stream
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 60) begin
      tick();
      guard++;
    end
    chk("mid_valid", 64'(out_valid), 64'(1));
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check_reset("midrst");
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    run_check("zero", -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_matmul_engine.md
Name: tpu_matmul_engine

Overview:
Parametrised N x N output-stationary systolic matrix-multiply engine with on-block operand buffers, a sequencing FSM and a handshaked result stream. It computes C = A x B for signed DATA_WIDTH operands. The TPU top instantiates it in place of the fixed 4x4 array, memory and control triple. It adds valid/ready loading, start/abort control, saturating output narrowing and row-major result draining.

Parameters:
N, 4, array dimension; A, B and C are N x N; N >= 2.
DATA_WIDTH, 8, operand width, signed two's complement.
ACC_WIDTH, 18, accumulator width, signed; must be >= 2*DATA_WIDTH.
OUT_WIDTH, 8, result stream width; must be <= ACC_WIDTH.
SATURATE, 1, 1 = clamp to the signed OUT_WIDTH range; 0 = truncate to the low OUT_WIDTH bits.
IDX_W, derived localparam, max(1, clog2(N)).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous reset, active-high (1 = reset). The name is kept for codebase consistency.
wr_valid  in  1  operand write request.
wr_ready  out  1  high only in IDLE; a write occurs when wr_valid && wr_ready.
wr_sel  in  1  0 = buffer A, 1 = buffer B.
wr_row  in  IDX_W  element row.
wr_col  in  IDX_W  element column.
wr_data  in  DATA_WIDTH  element value.
start  in  1  begin a multiply; sampled in IDLE only.
abort  in  1  synchronous abort.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the final result beat is accepted.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accept.
out_data  out  OUT_WIDTH  narrowed C[out_row][out_col].
out_row  out  IDX_W  row index of the current beat.
out_col  out  IDX_W  column index of the current beat.
out_last  out  1  high on the beat for C[N-1][N-1].

Behaviour:
Reset:
- FSM goes to IDLE.
- Both operand buffers and all accumulators are zeroed.
- Outputs: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, wr_ready=1.
- Reset asserted mid-operation forces this state immediately, with no partial stream.

FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> IDLE.
- IDLE: accepts writes. Buffers retain contents across operations, so re-running start repeats the last product. If start is sampled high (a write in the same cycle takes effect first), next state is CLEAR.
- CLEAR: 1 cycle; zeroes all N*N accumulators.
- RUN: exactly 3N-2 cycles.
  - At RUN cycle k, row i is fed A[i][k-i] and column j is fed B[k-j][j]; 0 is fed when the index is out of 0..N-1.
  - PE(i,j) does acc += a*b, forwards a right and b down through registers.
  - All MACs complete within RUN.
- DRAIN: streams C row-major, (0,0),(0,1)...(N-1,N-1), N*N beats.
  - out_valid first rises exactly 3N cycles after the edge that sampled start (N=4: 12 cycles).
  - A beat advances only on out_valid && out_ready.
  - While stalled, out_data, out_row, out_col and out_last hold stable.
  - Back-to-back acceptance gives one beat per cycle.
  - After the last beat is accepted: out_valid=0 and done=1 for one cycle, then IDLE.

Ignored inputs:
- start while busy is ignored.
- wr_valid while busy is ignored (wr_ready=0); buffers are unchanged.

Abort (any non-IDLE state):
- Next cycle: IDLE, out_valid=0, done stays 0.
- Buffers are kept; accumulators are left stale until the next CLEAR.
- Abort in IDLE has no effect; abort has priority over start in the same cycle.

Arithmetic:
- Product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
- Accumulation wraps modulo 2^ACC_WIDTH.

Narrowing:
- SATURATE=1: values > 2^(OUT_WIDTH-1)-1 clamp to the max; values < -2^(OUT_WIDTH-1) clamp to the min.
- SATURATE=0: acc[OUT_WIDTH-1:0].

Out-of-range write indices (possible only when N is not a power of 2) are dropped.

Test Plan:
1. N=4. Load A=identity, B[r][c]=4r+c, start, out_ready=1 -> 16 beats: out_data=0,1,...,15 in row-major order; out_last only on (3,3); done pulses once; first out_valid 12 cycles after start.
2. A all 0xFF (-1), B all 0x02 -> every beat = 0xF8 (-8).
3. A and B all 0x7F -> acc=64516. SATURATE=1: every beat 0x7F. SATURATE=0: every beat 0x04.
4. Backpressure: drop out_ready for 5 cycles while beat (1,1) is presented -> beat (1,1) held unchanged throughout; still exactly 16 accepted beats, none duplicated or lost.
5. Assert abort on the 3rd RUN cycle -> busy=0 next cycle, no out_valid, no done. Then start again without reloading -> result matches test 1.
6. Write attempts during RUN (wr_sel=0, index (0,0), data 0x55) are ignored. Assert rst_n mid-DRAIN -> outputs at reset values immediately. After release, start without loading -> all 16 beats 0.
